// File: rtl/interrupt_scheduler.sv
// Interrupt scheduler: config registers, edge-detected pending bits and a
// fixed-priority request/acknowledge/done handshake toward the core.
module interrupt_scheduler #(
    parameter int N_SRC = 4,
    parameter int IDW   = $clog2(N_SRC)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [31:0]      cfg_wdata,
    output logic [31:0]      cfg_rdata,
    input  logic             timer_fire,
    input  logic [N_SRC-2:0] ext_irq,
    output logic             timer_en,
    output logic [31:0]      timer_max,
    output logic             irq_req,
    output logic [IDW-1:0]   irq_id,
    input  logic             irq_ack,
    input  logic             irq_done,
    output logic             irq_busy
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t           state, state_nxt;
    logic [31:0]      tmax;
    logic [N_SRC-1:0] mask;
    logic [1:0]       ctrl;
    logic [N_SRC-1:0] pend;
    logic [N_SRC-2:0] ext_q;
    logic [N_SRC-1:0] pend_set;
    logic [N_SRC-1:0] pend_clr;
    logic [N_SRC-1:0] pend_en;
    logic [IDW-1:0]   id_nxt;

    function automatic logic [IDW-1:0] lowest_idx(input logic [N_SRC-1:0] v);
        lowest_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = IDW'(i);
        end
    endfunction

    assign pend_set = {ext_irq & ~ext_q, timer_fire};
    assign pend_en  = pend & mask;

    always_comb begin
        state_nxt = state;
        id_nxt    = irq_id;
        pend_clr  = '0;
        case (state)
            IDLE: begin
                // global_en and MASK only gate leaving IDLE; a live handshake is never withdrawn
                if (ctrl[1] && (|pend_en)) begin
                    state_nxt = REQ;
                    id_nxt    = lowest_idx(pend_en);
                end
            end
            REQ: begin
                if (irq_ack) begin
                    state_nxt = SERVICE;
                    for (int i = 0; i < N_SRC; i++) begin
                        pend_clr[i] = (irq_id == IDW'(i));
                    end
                end
            end
            SERVICE: begin
                if (irq_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state  <= IDLE;
            irq_id <= '0;
            tmax   <= 32'hFFFF_FFFF;
            mask   <= '0;
            ctrl   <= '0;
            pend   <= '0;
            ext_q  <= '0;
        end else begin
            state  <= state_nxt;
            irq_id <= id_nxt;
            ext_q  <= ext_irq;
            // a new event on the bit being acknowledged outranks the clear
            pend   <= (pend & ~pend_clr) | pend_set;
            if (cfg_we) begin
                case (cfg_addr)
                    2'd0:    tmax <= (cfg_wdata == 32'd0) ? 32'd1 : cfg_wdata;
                    2'd1:    mask <= cfg_wdata[N_SRC-1:0];
                    2'd2:    ctrl <= cfg_wdata[1:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        case (cfg_addr)
            2'd0:    cfg_rdata = tmax;
            2'd1:    cfg_rdata = 32'(mask);
            2'd2:    cfg_rdata = {30'd0, ctrl};
            default: cfg_rdata = 32'(pend);
        endcase
    end

    assign irq_req   = (state == REQ);
    assign irq_busy  = (state == SERVICE);
    assign timer_en  = ctrl[0];
    assign timer_max = tmax;

endmodule

// File: tb/tb_interrupt_scheduler.sv
// Bench for interrupt_scheduler: directed scenarios plus randomized traffic,
// with request events scored against a queue fed by a reference model.
module tb_interrupt_scheduler;

    localparam int N   = 4;
    localparam int IDW = $clog2(N);

    logic           clk;
    logic           nrst;
    logic           cfg_we;
    logic [1:0]     cfg_addr;
    logic [31:0]    cfg_wdata;
    logic [31:0]    cfg_rdata;
    logic           timer_fire;
    logic [N-2:0]   ext_irq;
    logic           timer_en;
    logic [31:0]    timer_max;
    logic           irq_req;
    logic [IDW-1:0] irq_id;
    logic           irq_ack;
    logic           irq_done;
    logic           irq_busy;

    interrupt_scheduler #(.N_SRC(N)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_rdata  (cfg_rdata),
        .timer_fire (timer_fire),
        .ext_irq    (ext_irq),
        .timer_en   (timer_en),
        .timer_max  (timer_max),
        .irq_req    (irq_req),
        .irq_id     (irq_id),
        .irq_ack    (irq_ack),
        .irq_done   (irq_done),
        .irq_busy   (irq_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int id;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   prev_req = 1'b0;

    // Reference model: phase 0 = idle, 1 = waiting for ack, 2 = handler running
    logic [31:0]  m_tmax;
    logic [N-1:0] m_mask;
    logic [1:0]   m_ctrl;
    logic [N-1:0] m_pend;
    logic [N-2:0] m_prev;
    int           m_phase;
    int           m_id;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [1:0] a);
        case (a)
            2'd0:    return m_tmax;
            2'd1:    return 32'(m_mask);
            2'd2:    return {30'd0, m_ctrl};
            default: return 32'(m_pend);
        endcase
    endfunction

    task automatic model_reset();
        m_tmax  = 32'hFFFF_FFFF;
        m_mask  = '0;
        m_ctrl  = '0;
        m_pend  = '0;
        m_prev  = '0;
        m_phase = 0;
        m_id    = 0;
        exp_q.delete();
    endtask

    // Compute the model's next state from the applied inputs, then commit at the edge
    task automatic tick();
        logic [N-1:0] set_v, clr_v, en_v;
        logic [31:0]  n_tmax;
        logic [N-1:0] n_mask;
        logic [1:0]   n_ctrl;
        int           n_phase, n_id;
        bit           push;
        set_v   = {ext_irq & ~m_prev, timer_fire};
        clr_v   = '0;
        en_v    = m_pend & m_mask;
        n_phase = m_phase;
        n_id    = m_id;
        push    = 1'b0;
        if (m_phase == 0) begin
            if (m_ctrl[1] && en_v != '0) begin
                n_phase = 1;
                n_id    = lowest(en_v);
                push    = 1'b1;
            end
        end else if (m_phase == 1) begin
            if (irq_ack) begin
                n_phase = 2;
                clr_v[m_id] = 1'b1;
            end
        end else if (irq_done) begin
            n_phase = 0;
        end
        n_tmax = m_tmax;
        n_mask = m_mask;
        n_ctrl = m_ctrl;
        if (cfg_we) begin
            if (cfg_addr == 2'd0) n_tmax = (cfg_wdata == 0) ? 32'd1 : cfg_wdata;
            if (cfg_addr == 2'd1) n_mask = cfg_wdata[N-1:0];
            if (cfg_addr == 2'd2) n_ctrl = cfg_wdata[1:0];
        end
        @(posedge clk);
        cyc++;
        m_pend  = (m_pend & ~clr_v) | set_v;
        m_prev  = ext_irq;
        m_phase = n_phase;
        m_id    = n_id;
        m_tmax  = n_tmax;
        m_mask  = n_mask;
        m_ctrl  = n_ctrl;
        if (push) exp_q.push_back('{cyc, n_id});
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic rd_const(input string name, input logic [1:0] a, input logic [31:0] exp);
        cfg_addr = a;
        #1;
        chk(name, cfg_rdata, exp);
    endtask

    task automatic clear_inputs();
        cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = '0;
        timer_fire = 1'b0; ext_irq = '0; irq_ack = 1'b0; irq_done = 1'b0;
    endtask

    // Reset is asserted between clock edges so its effect is purely asynchronous
    task automatic do_reset();
        clear_inputs();
        #1 nrst = 1'b0;
        #1;
        model_reset();
        chk("rst_irq_req", irq_req, 0);
        chk("rst_irq_busy", irq_busy, 0);
        chk("rst_timer_en", timer_en, 0);
        chk("rst_timer_max", timer_max, 32'hFFFF_FFFF);
        chk("rst_irq_id", irq_id, 0);
        rd_const("rst_tmax", 2'd0, 32'hFFFF_FFFF);
        rd_const("rst_mask", 2'd1, 0);
        rd_const("rst_ctrl", 2'd2, 0);
        rd_const("rst_pend", 2'd3, 0);
        @(posedge clk);
        @(posedge clk);
        #2 nrst = 1'b1;
        #1;
    endtask

    always @(negedge clk) begin
        if (!nrst) begin
            prev_req = 1'b0;
        end else begin
            if (irq_req && !prev_req) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_req: got request id %0d, none expected (t=%0t)", irq_id, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("req_cycle", cyc, mon_e.cyc);
                    chk("req_id", 32'(irq_id), mon_e.id);
                end
            end
            chk("req_level", irq_req, (m_phase == 1));
            chk("busy_level", irq_busy, (m_phase == 2));
            if (m_phase != 0) chk("id_hold", 32'(irq_id), m_id);
            chk("timer_en", timer_en, m_ctrl[0]);
            chk("timer_max", timer_max, m_tmax);
            prev_req = irq_req;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst = 1'b1;
        clear_inputs();
        do_reset();

        // TMAX write of zero is stored as one
        wr(2'd0, 32'd0);
        rd_const("tmax_zero_rd", 2'd0, 32'd1);
        chk("tmax_zero_out", timer_max, 32'd1);

        // timer and ext source 1 pend together; lowest index wins first
        wr(2'd1, 32'hF);
        wr(2'd2, 32'h3);
        ext_irq = 3'b001; timer_fire = 1'b1;
        tick();
        timer_fire = 1'b0;
        rd_const("coll_pend", 2'd3, 32'b0011);
        tick();
        chk("coll_req0", irq_req, 1);
        chk("coll_id0", 32'(irq_id), 0);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        chk("coll_busy", irq_busy, 1);
        irq_done = 1'b1; tick(); irq_done = 1'b0;
        tick();
        chk("coll_req1", irq_req, 1);
        chk("coll_id1", 32'(irq_id), 1);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        irq_done = 1'b1; tick(); irq_done = 1'b0;
        ext_irq = '0;

        // masked timer event stays pending until its mask bit opens
        wr(2'd1, 32'b0010);
        timer_fire = 1'b1; tick(); timer_fire = 1'b0;
        tick();
        chk("mask_noreq", irq_req, 0);
        rd_const("mask_pend", 2'd3, 32'b0001);
        wr(2'd1, 32'b0001);
        chk("mask_wr_noreq", irq_req, 0);
        tick();
        chk("mask_req", irq_req, 1);
        chk("mask_id", 32'(irq_id), 0);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        irq_done = 1'b1; tick(); irq_done = 1'b0;

        // new edge on source 2 in the same cycle as its ack keeps it pending
        wr(2'd1, 32'hF);
        ext_irq = 3'b010; tick();
        tick();
        chk("ack_coll_req", irq_req, 1);
        chk("ack_coll_id", 32'(irq_id), 2);
        ext_irq = 3'b000; tick();
        ext_irq = 3'b010; irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        rd_const("ack_coll_pend", 2'd3, 32'b0100);
        irq_done = 1'b1; tick(); irq_done = 1'b0;
        tick();
        chk("ack_coll_rereq", irq_req, 1);
        chk("ack_coll_reid", 32'(irq_id), 2);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        irq_done = 1'b1; tick(); irq_done = 1'b0;
        ext_irq = '0; tick();

        // disabling global_en during service stops further requests
        timer_fire = 1'b1; tick(); timer_fire = 1'b0;
        tick();
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        ext_irq = 3'b001; tick();
        wr(2'd2, 32'h0);
        chk("gdis_busy", irq_busy, 1);
        irq_done = 1'b1; tick(); irq_done = 1'b0;
        tick(); tick(); tick();
        chk("gdis_noreq", irq_req, 0);
        chk("gdis_idle", irq_busy, 0);
        rd_const("gdis_pend", 2'd3, 32'b0010);

        // reset while a request is outstanding
        wr(2'd2, 32'h3);
        tick();
        chk("rst_pre_req", irq_req, 1);
        do_reset();

        // randomized traffic
        wr(2'd1, 32'hF);
        wr(2'd2, 32'h3);
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < N - 1; b++) begin
                if ($urandom_range(0, 7) == 0) ext_irq[b] = ~ext_irq[b];
            end
            timer_fire = ($urandom_range(0, 15) == 0);
            irq_ack    = ($urandom_range(0, 2) == 0);
            irq_done   = ($urandom_range(0, 3) == 0);
            cfg_we     = ($urandom_range(0, 19) == 0);
            cfg_addr   = 2'($urandom_range(0, 3));
            cfg_wdata  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            if (cfg_we && cfg_addr == 2'd2) cfg_wdata[1] = ($urandom_range(0, 3) != 0);
            #1;
            chk("rand_rdata", cfg_rdata, exp_rd(cfg_addr));
            tick();
            if (i == 1500) begin
                do_reset();
                wr(2'd1, 32'hF);
                wr(2'd2, 32'h3);
            end
        end
        clear_inputs();
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
